// File: rtl/traffic_ctrl_nway.sv
// Round-robin light controller for NUM_APPR approaches with latched pedestrian
// walk, emergency all-red preemption and a blinking-yellow power-outage mode.
module traffic_ctrl_nway #(
  parameter int          NUM_APPR    = 2,
  parameter int          TICK_DIV    = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned T_GREEN     = 300000000,
  parameter int unsigned T_MIN_GREEN = 50000000,
  parameter int unsigned T_YELLOW    = 50000000,
  parameter int unsigned T_ALLRED    = 25000000,
  parameter int unsigned T_PED       = 600000000,
  parameter int unsigned T_EMERG     = 50000000,
  parameter int unsigned T_FLASH     = 25000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        emergency,
  input  logic                        power_outage,
  input  logic                        ped_req,
  output logic [3*NUM_APPR-1:0]       lights,
  output logic [2:0]                  state,
  output logic [$clog2(NUM_APPR)-1:0] active,
  output logic                        ped_walk,
  output logic                        ped_pending
);

  localparam int AW = $clog2(NUM_APPR);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [AW-1:0]    LAST_APPR   = AW'(NUM_APPR - 1);
  localparam logic [PW-1:0]    PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] EMERG_LAST  = CNT_W'(T_EMERG - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(T_FLASH - 1);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_PED    = 3'd3,
    S_EMERG  = 3'd4,
    S_FLASH  = 3'd5
  } state_t;

  state_t           state_r, state_n;
  logic [AW-1:0]    active_r, active_n;
  logic [PW-1:0]    presc_r, presc_n;
  logic [CNT_W-1:0] timer_r, timer_n;
  logic             ped_r, ped_n;
  logic             flash_r, flash_n;
  logic             tick;

  assign tick = (presc_r == PRESC_LAST);

  // State, timing and latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_ALLRED;
      active_r <= LAST_APPR;
      presc_r  <= '0;
      timer_r  <= '0;
      ped_r    <= 1'b0;
      flash_r  <= 1'b0;
    end else begin
      state_r  <= state_n;
      active_r <= active_n;
      presc_r  <= presc_n;
      timer_r  <= timer_n;
      ped_r    <= ped_n;
      flash_r  <= flash_n;
    end
  end

  // Next-state logic: outage beats emergency beats the normal cycle
  always_comb begin
    state_n  = state_r;
    active_n = active_r;
    flash_n  = flash_r;
    ped_n    = ped_r | ped_req;
    presc_n  = tick ? '0 : presc_r + PW'(1);
    timer_n  = tick ? timer_r + CNT_W'(1) : timer_r;

    if (power_outage) begin
      if (state_r != S_FLASH) begin
        state_n = S_FLASH;
        flash_n = 1'b1;
      end else if (tick && (timer_r == FLASH_LAST)) begin
        flash_n = ~flash_r;
        timer_n = '0;
      end else begin
        flash_n = flash_r;
      end
    end else if (state_r == S_FLASH) begin
      state_n  = S_ALLRED;
      active_n = LAST_APPR;
    end else if (emergency) begin
      if (state_r != S_EMERG) begin
        state_n = S_EMERG;
      end else begin
        // clearance countdown only starts once the request is gone
        presc_n = '0;
        timer_n = '0;
      end
    end else begin
      case (state_r)
        S_ALLRED: begin
          if (tick && (timer_r == ALLRED_LAST)) begin
            state_n  = S_GREEN;
            active_n = (active_r == LAST_APPR) ? '0 : active_r + AW'(1);
          end else begin
            state_n = S_ALLRED;
          end
        end
        S_GREEN: begin
          if (tick && ((timer_r == GREEN_LAST) || (ped_r && (timer_r >= MIN_LAST)))) begin
            state_n = S_YELLOW;
          end else begin
            state_n = S_GREEN;
          end
        end
        S_YELLOW: begin
          if (tick && (timer_r == YELLOW_LAST)) begin
            state_n = ped_r ? S_PED : S_ALLRED;
          end else begin
            state_n = S_YELLOW;
          end
        end
        S_PED: begin
          if (tick && (timer_r == PED_LAST)) begin
            state_n = S_ALLRED;
          end else begin
            state_n = S_PED;
          end
        end
        S_EMERG: begin
          if (tick && (timer_r == EMERG_LAST)) begin
            state_n = S_ALLRED;
          end else begin
            state_n = S_EMERG;
          end
        end
        default: state_n = S_ALLRED;
      endcase
    end

    if (state_n != state_r) begin
      presc_n = '0;
      timer_n = '0;
    end else begin
      presc_n = presc_n;
    end

    // entering the walk serves the latched request; a fresh pulse still re-arms it
    if ((state_n == S_PED) && (state_r != S_PED)) begin
      ped_n = ped_req;
    end else begin
      ped_n = ped_n;
    end
  end

  // Lamp decode from registered state only
  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_APPR; i++) begin
      case (state_r)
        S_GREEN:  lights[3*i +: 3] = (AW'(i) == active_r) ? 3'b001 : 3'b100;
        S_YELLOW: lights[3*i +: 3] = (AW'(i) == active_r) ? 3'b010 : 3'b100;
        S_FLASH:  lights[3*i +: 3] = flash_r ? 3'b010 : 3'b000;
        default:  lights[3*i +: 3] = 3'b100;
      endcase
    end
  end

  assign state       = state_r;
  assign active      = active_r;
  assign ped_walk    = (state_r == S_PED);
  assign ped_pending = ped_r;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed scenarios followed by randomized stimulus, every cycle checked
// against a cycle-count reference model of the intersection rules.
module tb_traffic_ctrl_nway;

  localparam int N   = 3;
  localparam int TD  = 2;
  localparam int TG  = 4;
  localparam int TMG = 2;
  localparam int TY  = 2;
  localparam int TAR = 1;
  localparam int TP  = 3;
  localparam int TE  = 2;
  localparam int TF  = 2;

  localparam int ST_ALLRED = 0, ST_GREEN = 1, ST_YELLOW = 2, ST_PED = 3, ST_EMERG = 4, ST_FLASH = 5;

  logic           clk = 1'b0;
  logic           reset, emergency, power_outage, ped_req;
  logic [3*N-1:0] lights;
  logic [2:0]     state;
  logic [1:0]     active;
  logic           ped_walk, ped_pending;

  int n_vec = 0;
  int n_err = 0;

  // reference model: state, cycles spent in it, served approach, latch, flash phase
  int m_st, m_el, m_act;
  bit m_ped, m_ph;

  traffic_ctrl_nway #(
    .NUM_APPR(N), .TICK_DIV(TD), .CNT_W(32),
    .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_YELLOW(TY), .T_ALLRED(TAR),
    .T_PED(TP), .T_EMERG(TE), .T_FLASH(TF)
  ) dut (
    .clk(clk), .reset(reset), .emergency(emergency), .power_outage(power_outage),
    .ped_req(ped_req), .lights(lights), .state(state), .active(active),
    .ped_walk(ped_walk), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dwell(input int st);
    case (st)
      ST_ALLRED: return TAR * TD;
      ST_GREEN:  return TG * TD;
      ST_YELLOW: return TY * TD;
      ST_PED:    return TP * TD;
      ST_EMERG:  return TE * TD;
      default:   return TF * TD;
    endcase
  endfunction

  function automatic logic [3*N-1:0] exp_lights();
    logic [3*N-1:0] l = '0;
    for (int i = 0; i < N; i++) begin
      case (m_st)
        ST_GREEN:  l[3*i +: 3] = (i == m_act) ? 3'b001 : 3'b100;
        ST_YELLOW: l[3*i +: 3] = (i == m_act) ? 3'b010 : 3'b100;
        ST_FLASH:  l[3*i +: 3] = m_ph ? 3'b010 : 3'b000;
        default:   l[3*i +: 3] = 3'b100;
      endcase
    end
    return l;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit p, input bit q);
    int  nst;
    bit  nped;
    bit  at_end;
    if (r) begin
      m_st = ST_ALLRED; m_el = 0; m_act = N - 1; m_ped = 1'b0; m_ph = 1'b0;
      return;
    end
    nst    = m_st;
    nped   = m_ped | q;
    at_end = (m_el + 1 == dwell(m_st));
    if (p) begin
      if (m_st != ST_FLASH) begin
        nst = ST_FLASH; m_ph = 1'b1;
      end else if ((m_el + 1) % (TF * TD) == 0) begin
        m_ph = !m_ph;
      end
    end else if (m_st == ST_FLASH) begin
      nst = ST_ALLRED; m_act = N - 1;
    end else if (e) begin
      if (m_st != ST_EMERG) nst = ST_EMERG;
      else m_el = -1;
    end else begin
      case (m_st)
        ST_ALLRED: if (at_end) begin nst = ST_GREEN; m_act = (m_act + 1) % N; end
        ST_GREEN:  if (at_end || (m_ped && ((m_el + 1) % TD == 0) && ((m_el + 1) / TD >= TMG)))
                     nst = ST_YELLOW;
        ST_YELLOW: if (at_end) nst = m_ped ? ST_PED : ST_ALLRED;
        ST_PED:    if (at_end) nst = ST_ALLRED;
        ST_EMERG:  if (at_end) nst = ST_ALLRED;
        default:   nst = ST_ALLRED;
      endcase
    end
    if (nst == ST_PED && m_st != ST_PED) nped = q;
    if (nst != m_st) m_el = 0;
    else m_el++;
    m_st  = nst;
    m_ped = nped;
  endtask

  task automatic cyc(input bit r, input bit e, input bit p, input bit q);
    reset = r; emergency = e; power_outage = p; ped_req = q;
    @(posedge clk);
    model_step(r, e, p, q);
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("active", 32'(active), 32'(m_act));
    chk("lights", 32'(lights), 32'(exp_lights()));
    chk("ped_walk", 32'(ped_walk), 32'(m_st == ST_PED));
    chk("ped_pending", 32'(ped_pending), 32'(m_ped));
  endtask

  task automatic idle_until(input int st, input int el);
    int n = 0;
    while (!(m_st == st && m_el == el) && n < 200) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_budget", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int em_left = 0;
    int po_left = 0;
    bit e, p, q, r;

    reset = 1'b1; emergency = 1'b0; power_outage = 1'b0; ped_req = 1'b0;
    #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_lights", 32'(lights), 32'h124);
    chk("reset_active", 32'(active), 32'd2);

    // first green to approach 0 after two cycles of clearance
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_green", 32'(lights), 32'h121);
    chk("first_green_act", 32'(active), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_yellow", 32'(state), 32'd2);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // pedestrian pulse early in a green cuts it to minimum green
    idle_until(ST_GREEN, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("min_green_exit", 32'(state), 32'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("walk_entry", 32'(ped_walk), 32'd1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // emergency mid-yellow
    idle_until(ST_YELLOW, 1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // outage with an emergency pulse inside it
    for (int i = 0; i < 20; i++) cyc(1'b0, (i >= 8 && i < 11), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // ped request together with emergency, then reset during the walk
    idle_until(ST_GREEN, 3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle_until(ST_PED, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_walk_act", 32'(active), 32'd2);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // outage released while emergency still high
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // randomized episodes
    for (int i = 0; i < 3000; i++) begin
      if (em_left == 0 && $urandom_range(0, 59) == 0) em_left = $urandom_range(1, 8);
      if (po_left == 0 && $urandom_range(0, 199) == 0) po_left = $urandom_range(1, 25);
      e = (em_left > 0);
      p = (po_left > 0);
      q = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 499) == 0);
      if (em_left > 0) em_left--;
      if (po_left > 0) po_left--;
      cyc(r, e, p, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
